param_data_cache: RTL and testbench

PARAM_DATA_CACHE -- requirements
Module: param_data_cache

---
 rtl/param_data_cache_if.sv | 33 +++
 rtl/param_data_cache.sv | 219 +++++++++++++++++++++
 tb/tb_param_data_cache.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_data_cache_if.sv
// Command, response, L2 and statistics signals of param_data_cache bundled into one interface.
// The cache connects through the slave modport; the requester/L2 side uses master.
interface param_data_cache_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 6
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [3:0]                  cmd_n;
    logic [ADDR_W-1:0]           cmd_addr;
    logic                        rsp_valid;
    logic                        rsp_hit;
    logic                        l2_req;
    logic                        l2_we;
    logic [ADDR_W-LINE_BITS-1:0] l2_addr;
    logic                        l2_ack;
    logic [31:0]                 hit_cnt;
    logic [31:0]                 miss_cnt;
    logic [31:0]                 read_cnt;
    logic [31:0]                 write_cnt;

    modport master (
        output cmd_valid, cmd_n, cmd_addr, l2_ack,
        input  cmd_ready, rsp_valid, rsp_hit, l2_req, l2_we, l2_addr,
        input  hit_cnt, miss_cnt, read_cnt, write_cnt
    );

    modport slave (
        input  cmd_valid, cmd_n, cmd_addr, l2_ack,
        output cmd_ready, rsp_valid, rsp_hit, l2_req, l2_we, l2_addr,
        output hit_cnt, miss_cnt, read_cnt, write_cnt
    );
endinterface

// File: rtl/param_data_cache.sv
// Set-associative write-back data cache tag/state controller with true-LRU replacement.
// Optional statistics counters are built when DCACHE_STATS_EN is defined.
module param_data_cache #(
    parameter int WAYS      = 4,
    parameter int SETS      = 16384,
    parameter int LINE_BITS = 6,
    parameter int ADDR_W    = 32
) (
    input logic               clk,
    input logic               reset_n,
    param_data_cache_if.slave bus
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int TAG_W  = ADDR_W - IDX_W - LINE_BITS;
    localparam int LINE_W = ADDR_W - LINE_BITS;

    localparam logic [3:0] CMD_READ  = 4'd0;
    localparam logic [3:0] CMD_WRITE = 4'd1;
    localparam logic [3:0] CMD_INV   = 4'd3;
    localparam logic [3:0] CMD_CLEAR = 4'd8;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [IDX_W-1:0]   clrPtr_q, clrPtr_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic               hit_q, hit_d;

    logic [WAYS-1:0]              valid_q [SETS];
    logic [WAYS-1:0]              dirty_q [SETS];
    logic [WAYS-1:0][TAG_W-1:0]   tag_q   [SETS];
    logic [WAYS-1:0][WAY_W-1:0]   age_q   [SETS];

    logic [IDX_W-1:0]           setIdx;
    logic [TAG_W-1:0]           reqTag;
    logic                       isRead, isWrite, isInv, isRdWr;
    logic [WAYS-1:0]            hitVec;
    logic                       anyHit;
    logic [WAY_W-1:0]           hitWay, victimWay, lruSel;
    logic [WAYS-1:0][WAY_W-1:0] newAge, clearAge;
    logic [LINE_W-1:0]          l2Addr;
    logic                       unusedAddrBits;

    assign unusedAddrBits = ^bus.cmd_addr[LINE_BITS-1:0];
    assign setIdx  = line_q[IDX_W-1:0];
    assign reqTag  = line_q[LINE_W-1 -: TAG_W];
    assign isRead  = (cmd_q == CMD_READ);
    assign isWrite = (cmd_q == CMD_WRITE);
    assign isInv   = (cmd_q == CMD_INV);
    assign isRdWr  = isRead | isWrite;
    assign anyHit  = |hitVec;

    // Victim: the LRU way, overridden by the lowest-index invalid way (scanned downwards so lowest wins).
    always_comb begin
        hitVec    = '0;
        hitWay    = '0;
        victimWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            hitVec[w] = valid_q[setIdx][w] && (tag_q[setIdx][w] == reqTag);
            if (hitVec[w]) hitWay = WAY_W'(w);
            if (age_q[setIdx][w] == WAY_W'(WAYS - 1)) victimWay = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[setIdx][w]) victimWay = WAY_W'(w);
        end
    end

    // Promote lruSel to age 0 and age every younger way by one, keeping the set a permutation.
    always_comb begin
        lruSel   = (state_q == FILL) ? victim_q : hitWay;
        newAge   = age_q[setIdx];
        clearAge = '0;
        for (int w = 0; w < WAYS; w++) begin
            clearAge[w] = WAY_W'(w);
            if (WAY_W'(w) == lruSel)
                newAge[w] = '0;
            else if (age_q[setIdx][w] < age_q[setIdx][lruSel])
                newAge[w] = age_q[setIdx][w] + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        line_d   = line_q;
        clrPtr_d = clrPtr_q;
        victim_d = victim_q;
        hit_d    = hit_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_n == CMD_CLEAR) begin
                        state_d  = CLEAR;
                        clrPtr_d = '0;
                    end else begin
                        state_d = LOOKUP;
                        cmd_d   = bus.cmd_n;
                        line_d  = bus.cmd_addr[ADDR_W-1:LINE_BITS];
                    end
                end
            end
            LOOKUP: begin
                hit_d   = (isRdWr || isInv) && anyHit;
                state_d = DONE;
                if (isRdWr && !anyHit) begin
                    victim_d = victimWay;
                    state_d  = (valid_q[setIdx][victimWay] && dirty_q[setIdx][victimWay]) ? WB : FILL;
                end else if (isInv && anyHit && dirty_q[setIdx][hitWay]) begin
                    victim_d = hitWay;
                    state_d  = WB;
                end
            end
            WB:      if (bus.l2_ack) state_d = isInv ? DONE : FILL;
            FILL:    if (bus.l2_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            CLEAR: begin
                clrPtr_d = clrPtr_q + 1'b1;
                if (clrPtr_q == IDX_W'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CLEAR;
            cmd_q    <= '0;
            line_q   <= '0;
            clrPtr_q <= '0;
            victim_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            line_q   <= line_d;
            clrPtr_q <= clrPtr_d;
            victim_q <= victim_d;
            hit_q    <= hit_d;
        end
    end

    // Tag/state memory has no reset of its own; the post-reset CLEAR sweep initialises it.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            valid_q[clrPtr_q] <= '0;
            dirty_q[clrPtr_q] <= '0;
            age_q[clrPtr_q]   <= clearAge;
        end else if (state_q == LOOKUP && isRdWr && anyHit) begin
            age_q[setIdx] <= newAge;
            if (isWrite) dirty_q[setIdx][hitWay] <= 1'b1;
        end else if (state_q == LOOKUP && isInv && anyHit && !dirty_q[setIdx][hitWay]) begin
            valid_q[setIdx][hitWay] <= 1'b0;
            dirty_q[setIdx][hitWay] <= 1'b0;
        end else if (state_q == WB && bus.l2_ack && isInv) begin
            valid_q[setIdx][victim_q] <= 1'b0;
            dirty_q[setIdx][victim_q] <= 1'b0;
        end else if (state_q == FILL && bus.l2_ack) begin
            tag_q[setIdx][victim_q]   <= reqTag;
            valid_q[setIdx][victim_q] <= 1'b1;
            dirty_q[setIdx][victim_q] <= isWrite;
            age_q[setIdx]             <= newAge;
        end
    end

    always_comb begin
        l2Addr = '0;
        if (state_q == WB)
            l2Addr = {tag_q[setIdx][victim_q], setIdx};
        else if (state_q == FILL)
            l2Addr = line_q;
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_hit   = (state_q == DONE) && hit_q;
    assign bus.l2_req    = (state_q == WB) || (state_q == FILL);
    assign bus.l2_we     = (state_q == WB);
    assign bus.l2_addr   = l2Addr;

`ifdef DCACHE_STATS_EN
    logic [31:0] hitCnt_q, missCnt_q, readCnt_q, writeCnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hitCnt_q   <= '0;
            missCnt_q  <= '0;
            readCnt_q  <= '0;
            writeCnt_q <= '0;
        end else if (state_q == IDLE && bus.cmd_valid) begin
            if (bus.cmd_n == CMD_CLEAR) begin
                hitCnt_q   <= '0;
                missCnt_q  <= '0;
                readCnt_q  <= '0;
                writeCnt_q <= '0;
            end else if (bus.cmd_n == CMD_READ) begin
                readCnt_q <= readCnt_q + 1'b1;
            end else if (bus.cmd_n == CMD_WRITE) begin
                writeCnt_q <= writeCnt_q + 1'b1;
            end
        end else if (state_q == LOOKUP && isRdWr) begin
            if (anyHit) hitCnt_q  <= hitCnt_q + 1'b1;
            else        missCnt_q <= missCnt_q + 1'b1;
        end
    end

    assign bus.hit_cnt   = hitCnt_q;
    assign bus.miss_cnt  = missCnt_q;
    assign bus.read_cnt  = readCnt_q;
    assign bus.write_cnt = writeCnt_q;
`else
    assign bus.hit_cnt   = '0;
    assign bus.miss_cnt  = '0;
    assign bus.read_cnt  = '0;
    assign bus.write_cnt = '0;
`endif
endmodule

// File: tb/tb_param_data_cache.sv
// Testbench for param_data_cache (WAYS=4, SETS=16): table-driven command vectors with a response
// scoreboard, an L2 responder acking one cycle after l2_req, plus reset and clear sweep sequences.
module tb_param_data_cache;
    localparam int SETS = 16;
`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        expHit;
        logic        hasWb;
        logic [25:0] wbAddr;
        logic        hasFill;
        logic [25:0] fillAddr;
        logic        cntChk;
        int          hitC, missC, readC, writeC;
    } vec_t;

    typedef struct {
        logic        expHit;
        logic        hasWb;
        logic [25:0] wbAddr;
        logic        hasFill;
        logic [25:0] fillAddr;
        int          l2Start;
    } exp_t;

    typedef struct {
        logic        we;
        logic [25:0] addr;
    } l2op_t;

    logic  clk;
    logic  reset_n;
    int    nChecks = 0;
    int    nFail   = 0;
    exp_t  expQ[$];
    l2op_t obsL2[$];
    vec_t  vecs[24];

    param_data_cache_if #(.ADDR_W(32), .LINE_BITS(6)) bus ();

    param_data_cache #(.WAYS(4), .SETS(SETS), .LINE_BITS(6), .ADDR_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // L2 model: acknowledges one cycle after it first sees a request and logs every transfer.
    initial begin
        l2op_t op;
        bus.l2_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.l2_req && !bus.l2_ack) begin
                op.we   = bus.l2_we;
                op.addr = bus.l2_addr;
                obsL2.push_back(op);
                bus.l2_ack = 1'b1;
            end else begin
                bus.l2_ack = 1'b0;
            end
        end
    end

    function automatic vec_t mkVec(input logic [3:0] cmd, input logic [31:0] addr, input logic hit,
                                   input logic wb, input logic [25:0] wbA, input logic fill,
                                   input logic [25:0] fillA, input logic cntChk,
                                   input int h, input int m, input int r, input int w);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.expHit = hit;
        v.hasWb = wb; v.wbAddr = wbA; v.hasFill = fill; v.fillAddr = fillA;
        v.cntChk = cntChk; v.hitC = h; v.missC = m; v.readC = r; v.writeC = w;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkCounters(input string name, input int h, input int m, input int r, input int w);
        checkOutput({name, " hit_cnt"},   bus.hit_cnt,   STATS ? 32'(h) : 32'd0);
        checkOutput({name, " miss_cnt"},  bus.miss_cnt,  STATS ? 32'(m) : 32'd0);
        checkOutput({name, " read_cnt"},  bus.read_cnt,  STATS ? 32'(r) : 32'd0);
        checkOutput({name, " write_cnt"}, bus.write_cnt, STATS ? 32'(w) : 32'd0);
    endtask

    // Counts cycles with cmd_ready low from the current negedge; the sweep must not respond.
    task automatic sweepCheck(input string name);
        int   lowCycles = 0;
        logic sawRsp    = 1'b0;
        while (!bus.cmd_ready && lowCycles < 100) begin
            if (bus.rsp_valid) sawRsp = 1'b1;
            @(negedge clk);
            lowCycles++;
        end
        checkOutput({name, " ready-low cycles"}, 32'(lowCycles), 32'(SETS));
        checkOutput({name, " rsp during sweep"}, {31'd0, sawRsp}, 32'd0);
        checkCounters(name, 0, 0, 0, 0);
    endtask

    task automatic waitReady(output logic ok);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = bus.cmd_ready;
    endtask

    task automatic doClear(input int idx);
        logic ok;
        waitReady(ok);
        checkOutput($sformatf("vec%0d ready for clear", idx), {31'd0, ok}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_n     = 4'd8;
        bus.cmd_addr  = 32'd0;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        sweepCheck($sformatf("vec%0d clear", idx));
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        logic  ok;
        logic  gotRsp = 1'b0;
        int    waited = 0;
        int    nGot;
        int    pos;
        exp_t  e;
        string tag = $sformatf("vec%0d", idx);
        waitReady(ok);
        checkOutput({tag, " cmd_ready"}, {31'd0, ok}, 32'd1);
        if (!ok) return;
        bus.cmd_valid = 1'b1;
        bus.cmd_n     = v.cmd;
        bus.cmd_addr  = v.addr;
        e.expHit = v.expHit; e.hasWb = v.hasWb; e.wbAddr = v.wbAddr;
        e.hasFill = v.hasFill; e.fillAddr = v.fillAddr; e.l2Start = obsL2.size();
        expQ.push_back(e);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        while (waited < 200) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                gotRsp = 1'b1;
                break;
            end
            waited++;
        end
        checkOutput({tag, " rsp_valid seen"}, {31'd0, gotRsp}, 32'd1);
        e = expQ.pop_front();
        if (!gotRsp) return;
        checkOutput({tag, " rsp_hit"}, {31'd0, bus.rsp_hit}, {31'd0, e.expHit});
        nGot = obsL2.size() - e.l2Start;
        checkOutput({tag, " l2 transfers"}, 32'(nGot), 32'(int'(e.hasWb) + int'(e.hasFill)));
        if (nGot == int'(e.hasWb) + int'(e.hasFill)) begin
            pos = e.l2Start;
            if (e.hasWb) begin
                checkOutput({tag, " wb l2_we"},   {31'd0, obsL2[pos].we}, 32'd1);
                checkOutput({tag, " wb l2_addr"}, 32'(obsL2[pos].addr), 32'(e.wbAddr));
                pos++;
            end
            if (e.hasFill) begin
                checkOutput({tag, " fill l2_we"},   {31'd0, obsL2[pos].we}, 32'd0);
                checkOutput({tag, " fill l2_addr"}, 32'(obsL2[pos].addr), 32'(e.fillAddr));
            end
        end
        if (!e.hasWb && !e.hasFill)
            checkOutput({tag, " rsp latency"}, 32'(waited + 1), 32'd2);
        if (v.cntChk) checkCounters(tag, v.hitC, v.missC, v.readC, v.writeC);
    endtask

    initial begin
        logic ok;
        int   n;
        vecs[0]  = mkVec(4'd0, 32'h1040, 0, 0, 26'h0,  1, 26'h41, 0, 0, 0, 0, 0);
        vecs[1]  = mkVec(4'd0, 32'h1040, 1, 0, 26'h0,  0, 26'h0,  1, 1, 1, 2, 0);
        vecs[2]  = mkVec(4'd8, 32'h0,    0, 0, 26'h0,  0, 26'h0,  0, 0, 0, 0, 0);
        vecs[3]  = mkVec(4'd1, 32'h0040, 0, 0, 26'h0,  1, 26'h01, 0, 0, 0, 0, 0);
        vecs[4]  = mkVec(4'd1, 32'h0440, 0, 0, 26'h0,  1, 26'h11, 0, 0, 0, 0, 0);
        vecs[5]  = mkVec(4'd1, 32'h0840, 0, 0, 26'h0,  1, 26'h21, 0, 0, 0, 0, 0);
        vecs[6]  = mkVec(4'd1, 32'h0C40, 0, 0, 26'h0,  1, 26'h31, 0, 0, 0, 0, 0);
        vecs[7]  = mkVec(4'd1, 32'h1040, 0, 1, 26'h01, 1, 26'h41, 1, 0, 5, 0, 5);
        vecs[8]  = mkVec(4'd8, 32'h0,    0, 0, 26'h0,  0, 26'h0,  0, 0, 0, 0, 0);
        vecs[9]  = mkVec(4'd0, 32'h0040, 0, 0, 26'h0,  1, 26'h01, 0, 0, 0, 0, 0);
        vecs[10] = mkVec(4'd0, 32'h0440, 0, 0, 26'h0,  1, 26'h11, 0, 0, 0, 0, 0);
        vecs[11] = mkVec(4'd0, 32'h0840, 0, 0, 26'h0,  1, 26'h21, 0, 0, 0, 0, 0);
        vecs[12] = mkVec(4'd0, 32'h0C40, 0, 0, 26'h0,  1, 26'h31, 0, 0, 0, 0, 0);
        vecs[13] = mkVec(4'd0, 32'h0040, 1, 0, 26'h0,  0, 26'h0,  0, 0, 0, 0, 0);
        vecs[14] = mkVec(4'd0, 32'h1040, 0, 0, 26'h0,  1, 26'h41, 0, 0, 0, 0, 0);
        vecs[15] = mkVec(4'd0, 32'h0040, 1, 0, 26'h0,  0, 26'h0,  0, 0, 0, 0, 0);
        vecs[16] = mkVec(4'd0, 32'h0440, 0, 0, 26'h0,  1, 26'h11, 0, 0, 0, 0, 0);
        vecs[17] = mkVec(4'd1, 32'h0040, 1, 0, 26'h0,  0, 26'h0,  0, 0, 0, 0, 0);
        vecs[18] = mkVec(4'd3, 32'h0040, 1, 1, 26'h01, 0, 26'h0,  0, 0, 0, 0, 0);
        vecs[19] = mkVec(4'd0, 32'h0040, 0, 0, 26'h0,  1, 26'h01, 0, 0, 0, 0, 0);
        vecs[20] = mkVec(4'd3, 32'h0840, 0, 0, 26'h0,  0, 26'h0,  0, 0, 0, 0, 0);
        vecs[21] = mkVec(4'd3, 32'h1040, 1, 0, 26'h0,  0, 26'h0,  0, 0, 0, 0, 0);
        vecs[22] = mkVec(4'd0, 32'h1040, 0, 0, 26'h0,  1, 26'h41, 0, 0, 0, 0, 0);
        vecs[23] = mkVec(4'd5, 32'h0040, 0, 0, 26'h0,  0, 26'h0,  1, 3, 8, 10, 1);

        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_n     = 4'd0;
        bus.cmd_addr  = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        checkOutput("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        checkOutput("reset rsp_hit",   {31'd0, bus.rsp_hit},   32'd0);
        checkOutput("reset l2_req",    {31'd0, bus.l2_req},    32'd0);
        checkOutput("reset l2_addr",   32'(bus.l2_addr),       32'd0);
        reset_n = 1'b1;
        sweepCheck("reset release");

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].cmd == 4'd8) doClear(i);
            else                     applyStimulus(i, vecs[i]);
        end

        // Reset asserted mid-fill: L2 request must drop at once and a fresh sweep must follow.
        waitReady(ok);
        checkOutput("midreset cmd_ready", {31'd0, ok}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_n     = 4'd0;
        bus.cmd_addr  = 32'h2040;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.l2_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midreset l2_req raised", {31'd0, bus.l2_req}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midreset l2_req",    {31'd0, bus.l2_req},    32'd0);
        checkOutput("midreset l2_we",     {31'd0, bus.l2_we},     32'd0);
        checkOutput("midreset l2_addr",   32'(bus.l2_addr),       32'd0);
        checkOutput("midreset cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        checkOutput("midreset read_cnt",  bus.read_cnt,           32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sweepCheck("midreset release");
        applyStimulus(24, mkVec(4'd0, 32'h1040, 0, 0, 26'h0, 1, 26'h41, 1, 0, 1, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end
endmodule
